demux1x2_stream: RTL
====================

# demux1x2_stream

- Packet-aware 1-to-2 stream demultiplexer: the receive-side counterpart of the 2:1 select mux.
- Steers a valid/ready input stream to one of two output channels. The channel is chosen on a packet's first beat and held until its last beat.
- Each output has a one-entry registered stage and a per-channel packet counter.
- Sits between a shared source and two independent consumers.

## Interface
Parameters:
- WIDTH, 8, data width of every beat
- CNTW, 16, width of each per-channel packet counter

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  input  1  rising-edge clock
  - rst  input  1  synchronous active-high reset
- Input stream:
  - in_data  input  WIDTH  input beat
  - in_valid  input  1  beat present
  - in_last  input  1  final beat of packet
  - in_sel  input  1  destination (0 → ch0, 1 → ch1); sampled only on a packet's first beat
  - in_ready  output  1  beat accepted when in_valid & in_ready
- Channel 0:
  - o0_data  output  WIDTH  channel 0 beat
  - o0_valid  output  1  channel 0 beat present
  - o0_last  output  1  channel 0 final beat
  - o0_ready  input  1  channel 0 consumer ready
- Channel 1:
  - o1_data / o1_valid / o1_last / o1_ready: same as channel 0, for channel 1
- Counters:
  - pkt_cnt0  output  CNTW  packets accepted for ch0
  - pkt_cnt1  output  CNTW  packets accepted for ch1

## Operation
- **FSM states:** ST_IDLE (between packets), ST_ROUTE0, ST_ROUTE1 (mid-packet, destination locked).
- **ST_IDLE:**
  - Target = in_sel.
  - On an accepted beat with in_last=0: go to ST_ROUTE<in_sel>.
  - On an accepted beat with in_last=1: stay in ST_IDLE (single-beat packet).
- **ST_ROUTEn:**
  - Target = n; in_sel is ignored.
  - On an accepted beat with in_last=1: return to ST_IDLE.
- **Output stage (each channel, one entry):**
  - Free when on_valid=0, or when on_valid & on_ready this cycle.
  - in_ready = target stage free. Combinational from on_ready; no other path.
- **Accepted beat:** captured into the target stage as {data, last}; on_valid=1 next cycle.
- **Non-target stage:** unaffected; it drains independently.
- **Held beat:** on_data/on_last stay stable while on_valid & !on_ready.
- **Counters:**
  - pkt_cntn increments on each accepted beat with in_last=1 routed to ch n.
  - Wraps from 2^CNTW−1 to 0.
- **Values after rst:**
  - state = ST_IDLE
  - o0_valid = o1_valid = 0
  - o0_data = o1_data = 0, o0_last = o1_last = 0
  - pkt_cnt0 = pkt_cnt1 = 0
  - in_ready reflects the empty stages (1 in ST_IDLE)
- **Reset mid-packet:** the partial packet is abandoned. Held beats are dropped. Next accepted beat is treated as a first beat.
- **in_valid=0:** no state change, even mid-packet.

## Timing
- **Latency:** accept at edge k → on_valid=1 after edge k, i.e. 1 cycle.
- **Throughput:** 1 beat/cycle per channel when on_ready=1. Drain and refill of the same stage in one cycle is required.
- **Channel switch:** no bubble. Last beat to ch0 at edge k and first beat to ch1 at edge k+1 is legal if ch1 is free.
- **Blocking:** a stalled target blocks the input; head-of-line blocking is intended. The other channel continues draining.
- **Counter timing:** pkt_cntn updates at the same edge the last beat is accepted; visible the following cycle.
- **rst priority:** rst=1 overrides any simultaneous accept or drain in that cycle.

## Structure
- **Package demux_pkg holds:**
  - state encodings: ST_IDLE=2'd0, ST_ROUTE0=2'd1, ST_ROUTE1=2'd2 (2'd3 illegal → ST_IDLE)
  - default WIDTH and CNTW
- **Sub-module out_stage:**
  - One-entry register with valid/ready, data, last.
  - Instantiated twice.
  - Exposes a "free" signal to the top.
- **Top-level demux1x2_stream holds:** FSM, target select, in_ready mux, counters.

## Test plan
1. **Reset:** assert rst 2 cycles with in_valid=1 → both on_valid=0, both on_data/on_last=0, counters 0, state ST_IDLE; in_ready=1 after release.
2. **Single-beat packets:** 0xA5 sel=0 last=1, then 0x3C sel=1 last=1, both o_ready=1.
   - o0 shows 0xA5 at cycle k+1; o1 shows 0x3C at k+2.
   - pkt_cnt0=1, pkt_cnt1=1.
3. **Packet lock:** 4-beat packet 0x10..0x13, sel=0 on beat 0, sel toggled to 1 on beats 1–3.
   - All four beats appear on o0, none on o1.
   - o0_last=1 only with 0x13; pkt_cnt0=1.
4. **Backpressure:** o1_ready=0 while a 3-beat packet targets ch1.
   - in_ready drops after first beat.
   - o1_data holds stable; no beat is lost or duplicated once o1_ready=1.
   - Meanwhile a prior ch0 beat drains normally.
5. **Full throughput and counter wrap:** CNTW=4, 17 back-to-back single-beat packets to ch0, o0_ready=1.
   - One beat per cycle, in_ready never 0.
   - pkt_cnt0 goes 15 → 0 → 1.
6. **Reset mid-packet:** rst after beat 2 of a 5-beat ch1 packet.
   - o1_valid=0 next cycle.
   - Following beat with sel=0 last=1 lands on o0; pkt_cnt1 remains 0.

Source files
------------

// File: rtl/demux_pkg.sv
// ----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the packet-aware 1:2 stream demultiplexer.
//   - default data / packet-counter widths
//   - FSM state encoding (2'd3 is unused and recovers to ST_IDLE)
//   - channel-index helper used to turn a routing state into a target
// ----------------------------------------------------------------------------
package demux_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNTW  = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ROUTE0 = 2'd1,
      ST_ROUTE1 = 2'd2
   } state_t;

   // Destination for the current beat: locked while mid-packet, otherwise
   // taken from the live select input.
   function automatic logic target_of(input state_t st, input logic sel);
      logic tgt;
      case (st)
         ST_ROUTE0: tgt = 1'b0;
         ST_ROUTE1: tgt = 1'b1;
         default:   tgt = sel;
      endcase
      return tgt;
   endfunction

endpackage

// File: rtl/demux1x2_stream_out_stage.sv
// ----------------------------------------------------------------------------
// out_stage
// One-entry registered output slot with valid/ready handshake.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load            capture load_data/load_last this cycle
//   load_data/last  beat to capture
//   ready           downstream consumer ready
//   valid/data/last registered beat presented downstream
//   free            slot can take a beat this cycle (empty or draining)
// ----------------------------------------------------------------------------
module out_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_last,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic             last,
   output logic             free
);

   logic             valid_reg;
   logic [WIDTH-1:0] data_reg;
   logic             last_reg;

   // Draining and refilling in the same cycle is allowed, so a full slot
   // whose consumer is ready counts as free.
   assign free = !valid_reg || ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
         last_reg  <= 1'b0;
      end else if (load) begin
         valid_reg <= 1'b1;
         data_reg  <= load_data;
         last_reg  <= load_last;
      end else if (ready) begin
         // Payload is left in place so data/last only move on a new load.
         valid_reg <= 1'b0;
      end
   end

   assign valid = valid_reg;
   assign data  = data_reg;
   assign last  = last_reg;

endmodule

// File: rtl/demux1x2_stream.sv
// ----------------------------------------------------------------------------
// demux1x2_stream
// Packet-aware 1:2 demultiplexer. The destination is sampled from in_sel on
// a packet's first beat and held until the last beat. Each channel has a
// one-entry registered stage and a packet counter.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_data/valid/last/sel, in_ready input stream and destination select
//   o0_* / o1_*                     channel 0 / channel 1 output streams
//   pkt_cnt0, pkt_cnt1              packets (last beats) accepted per channel
// ----------------------------------------------------------------------------
module demux1x2_stream
   import demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNTW  = DEF_CNTW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             in_last,
   input  logic             in_sel,
   output logic             in_ready,
   output logic [WIDTH-1:0] o0_data,
   output logic             o0_valid,
   output logic             o0_last,
   input  logic             o0_ready,
   output logic [WIDTH-1:0] o1_data,
   output logic             o1_valid,
   output logic             o1_last,
   input  logic             o1_ready,
   output logic [CNTW-1:0]  pkt_cnt0,
   output logic [CNTW-1:0]  pkt_cnt1
);

   state_t           state_reg;
   state_t           state_next;
   logic             target;
   logic             accept;

   logic [1:0]       stage_load;
   logic [1:0]       stage_ready;
   logic [1:0]       stage_valid;
   logic [1:0]       stage_last;
   logic [1:0]       stage_free;
   logic [WIDTH-1:0] stage_data [2];

   logic [CNTW-1:0]  pkt_cnt0_reg;
   logic [CNTW-1:0]  pkt_cnt1_reg;

   assign stage_ready = {o1_ready, o0_ready};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_stage
         out_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .load      (stage_load[gi]),
            .load_data (in_data),
            .load_last (in_last),
            .ready     (stage_ready[gi]),
            .valid     (stage_valid[gi]),
            .data      (stage_data[gi]),
            .last      (stage_last[gi]),
            .free      (stage_free[gi])
         );
      end
   endgenerate

   assign o0_valid = stage_valid[0];
   assign o0_data  = stage_data[0];
   assign o0_last  = stage_last[0];
   assign o1_valid = stage_valid[1];
   assign o1_data  = stage_data[1];
   assign o1_last  = stage_last[1];

   // Input readiness follows the targeted stage only; a stalled target
   // blocks the input even if the other channel is idle.
   assign target     = target_of(state_reg, in_sel);
   assign in_ready   = target ? stage_free[1] : stage_free[0];
   assign accept     = in_valid && in_ready;
   assign stage_load = {accept && target, accept && !target};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept && !in_last) begin
               state_next = in_sel ? ST_ROUTE1 : ST_ROUTE0;
            end
         end
         ST_ROUTE0, ST_ROUTE1: begin
            if (accept && in_last) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Counters wrap naturally at 2^CNTW.
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_cnt0_reg <= '0;
         pkt_cnt1_reg <= '0;
      end else if (accept && in_last) begin
         if (target) begin
            pkt_cnt1_reg <= pkt_cnt1_reg + CNTW'(1);
         end else begin
            pkt_cnt0_reg <= pkt_cnt0_reg + CNTW'(1);
         end
      end
   end

   assign pkt_cnt0 = pkt_cnt0_reg;
   assign pkt_cnt1 = pkt_cnt1_reg;

endmodule
